// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state encoding and default widths for the countdown timer
package countdown_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_IRQ_CNT_W = 8;
endpackage

// File: rtl/countdown_timer_irq_ctrl.sv
// timer_irq_ctrl: turns expiry pulses into a level irq, sticky overrun and saturating event count
module timer_irq_ctrl
  import countdown_timer_pkg::*;
#(
  parameter int IRQ_CNT_W = DEF_IRQ_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 expired,
  input  logic                 irq_ack,
  output logic                 irq,
  output logic                 overrun,
  output logic [IRQ_CNT_W-1:0] exp_cnt
);
  // An expiry coinciding with an ack wins: the ack only clears history older than this event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
      overrun <= 1'b0;
      exp_cnt <= '0;
    end else if (expired) begin
      irq <= 1'b1;
      overrun <= !irq_ack && (overrun || irq);
      exp_cnt <= irq_ack ? IRQ_CNT_W'(1) : exp_cnt + IRQ_CNT_W'(!(&exp_cnt));
    end else if (irq_ack) begin
      irq <= 1'b0;
      overrun <= 1'b0;
      exp_cnt <= '0;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable one-shot/periodic down-counter with expiry interrupt bookkeeping
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IRQ_CNT_W = DEF_IRQ_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [WIDTH-1:0]     load_value,
  input  logic                 periodic,
  input  logic                 stop,
  input  logic                 tick_en,
  input  logic                 irq_ack,
  output logic [WIDTH-1:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic                 expired,
  output logic                 irq,
  output logic                 overrun,
  output logic [IRQ_CNT_W-1:0] exp_cnt
);
  state_t state, state_n;
  logic [WIDTH-1:0] count_n, reload, reload_n;
  logic mode, mode_n, expired_n, last;
  assign load_ready = !stop;
  assign last = count == WIDTH'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      reload <= '0;
      mode <= 1'b0;
      expired <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      reload <= reload_n;
      mode <= mode_n;
      expired <= expired_n;
    end
  end
  // Priority stop > load > tick; a load or stop swallows any expiry due this cycle
  always_comb begin
    state_n = state;
    count_n = count;
    reload_n = reload;
    mode_n = mode;
    expired_n = 1'b0;
    if (stop) begin
      state_n = IDLE;
      count_n = '0;
    end else if (load_valid) begin
      reload_n = load_value;
      mode_n = periodic;
      count_n = load_value;
      state_n = load_value == '0 ? DONE : RUN;
      expired_n = load_value == '0;
    end else if (state == RUN && tick_en) begin
      expired_n = last;
      state_n = last && !mode ? DONE : RUN;
      count_n = !last ? count - WIDTH'(1) : mode ? reload : '0;
    end
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end
  timer_irq_ctrl #(.IRQ_CNT_W(IRQ_CNT_W)) u_irq (
    .clk(clk),
    .rst(rst),
    .expired(expired),
    .irq_ack(irq_ack),
    .irq(irq),
    .overrun(overrun),
    .exp_cnt(exp_cnt)
  );
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench comparing the timer against a cycle-level behavioural model
module tb_countdown_timer;
  logic clk = 0, rst = 1;
  logic load_valid = 0, periodic = 0, stop = 0, tick_en = 0, irq_ack = 0;
  logic [31:0] load_value = 0;
  logic load_ready, busy, done, expired, irq, overrun;
  logic [31:0] count;
  logic [7:0] exp_cnt;
  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] count;
    bit busy, done, exp, irq, ovr, rdy;
    logic [7:0] ecnt;
  } exp_t;
  exp_t q[$];

  bit m_running, m_finished, m_per, m_exp, m_irq, m_ovr;
  logic [31:0] m_count, m_reload;
  logic [7:0] m_ecnt;

  countdown_timer dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .periodic(periodic), .stop(stop), .tick_en(tick_en),
    .irq_ack(irq_ack), .count(count), .busy(busy), .done(done), .expired(expired),
    .irq(irq), .overrun(overrun), .exp_cnt(exp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_finished = 0; m_per = 0; m_exp = 0; m_irq = 0; m_ovr = 0;
    m_count = 0; m_reload = 0; m_ecnt = 0;
  endtask

  // Behavioural view: what the timer shows after the coming clock edge
  task automatic model(input bit st, input bit lv, input logic [31:0] v, input bit pr, input bit tk, input bit ack);
    if (m_exp) begin
      m_ovr = !ack && (m_ovr || m_irq);
      m_irq = 1;
      m_ecnt = ack ? 8'd1 : (m_ecnt == 8'd255 ? 8'd255 : m_ecnt + 8'd1);
    end else if (ack) begin
      m_irq = 0; m_ovr = 0; m_ecnt = 0;
    end
    m_exp = 0;
    if (st) begin
      m_running = 0; m_finished = 0; m_count = 0;
    end else if (lv) begin
      m_reload = v; m_per = pr; m_count = v;
      m_running = v != 0; m_finished = v == 0; m_exp = v == 0;
    end else if (m_running && tk) begin
      if (m_count == 1) begin
        m_exp = 1;
        if (m_per) m_count = m_reload;
        else begin m_count = 0; m_running = 0; m_finished = 1; end
      end else m_count = m_count - 1;
    end
  endtask

  task automatic cyc(input bit st, input bit lv, input logic [31:0] v, input bit pr, input bit tk, input bit ack);
    exp_t e;
    @(negedge clk);
    stop = st; load_valid = lv; load_value = v; periodic = pr; tick_en = tk; irq_ack = ack;
    model(st, lv, v, pr, tk, ack);
    e.count = m_count; e.busy = m_running; e.done = m_finished; e.exp = m_exp;
    e.irq = m_irq; e.ovr = m_ovr; e.ecnt = m_ecnt; e.rdy = !st;
    q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " count"}, count, 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " expired"}, 32'(expired), 0);
    chk({tag, " irq"}, 32'(irq), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
    chk({tag, " exp_cnt"}, 32'(exp_cnt), 0);
    chk({tag, " load_ready"}, 32'(load_ready), 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("count", count, e.count);
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("expired", 32'(expired), 32'(e.exp));
        chk("irq", 32'(irq), 32'(e.irq));
        chk("overrun", 32'(overrun), 32'(e.ovr));
        chk("exp_cnt", 32'(exp_cnt), 32'(e.ecnt));
        chk("load_ready", 32'(load_ready), 32'(e.rdy));
      end
    end
  end

  initial begin : driver
    model_reset();
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 0;
    // one-shot 5 with constant ticks, then ack
    cyc(0, 1, 5, 0, 1, 0);
    repeat (8) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    // periodic 3, no ack so overrun builds
    cyc(0, 1, 3, 1, 1, 0);
    repeat (10) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 1);
    // one-shot 2 with sparse ticks
    cyc(0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, i % 4 == 3, 0);
    // stop coincident with expiry, then load 7 coincident with expiry
    cyc(0, 1, 2, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(0, 1, 2, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 7, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    // load 0 pulses once regardless of mode
    cyc(0, 1, 0, 1, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    // periodic 1 expires every tick: saturate exp_cnt, then ack against a live expiry
    cyc(0, 1, 1, 1, 1, 1);
    repeat (300) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 32'hffff_ffff, 1, 1, 1);
    repeat (5) cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1);
    // async reset mid-run at count 40
    cyc(0, 1, 50, 1, 1, 0);
    repeat (10) cyc(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    tick_en = 0; load_valid = 0;
    #2 rst = 1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    cyc(0, 1, 4, 0, 1, 0);
    repeat (6) cyc(0, 0, 0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, 32'($urandom_range(0, 6)),
          1'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
    @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
